// File: rtl/gpu_mem_pkg.sv
// Shared constants and FSM encoding for the framebuffer store.
// Imported by the plane RAM and the frame_memory_unit top.
package gpu_mem_pkg;

    localparam int CHANNELS_DEF   = 3;
    localparam int ROW_PIXELS_DEF = 256;
    localparam int ADDR_W_DEF     = 10;

    // Width of one colour plane's slice in a packed row word.
    localparam int SLICE_W = ROW_PIXELS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } fmu_state_t;

endpackage

// File: rtl/frame_plane_ram.sv
// One colour plane: DEPTH rows of ROW_PIXELS bits, masked write/read
// port A plus an independent read-only port B.
module frame_plane_ram
    import gpu_mem_pkg::*;
#(
    parameter int ROW_PIXELS = SLICE_W,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 1 << ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_we,
    input  logic                  a_re,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [ROW_PIXELS-1:0] a_mask,
    input  logic [ROW_PIXELS-1:0] a_data,
    output logic [ROW_PIXELS-1:0] a_q,
    input  logic                  b_en,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic [ROW_PIXELS-1:0] b_q
);

    logic [ROW_PIXELS-1:0] mem [DEPTH];
    logic                  a_hit;
    logic                  b_hit;

    assign a_hit = int'(a_addr) < DEPTH;
    assign b_hit = int'(b_addr) < DEPTH;

    always_ff @(posedge clock) begin
        if (a_we && a_hit) begin
            mem[a_addr] <= (mem[a_addr] & ~a_mask) | (a_data & a_mask);
        end
    end

    // Non-blocking reads return pre-write data on a same-row collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_re) begin
                a_q <= a_hit ? mem[a_addr] : '0;
            end
            if (b_en) begin
                b_q <= b_hit ? mem[b_addr] : '0;
            end
        end
    end

endmodule

// File: rtl/frame_memory_unit.sv
// Multi-plane framebuffer: rasteriser draw port, scanout read port
// and a row-at-a-time clear engine sharing the draw write path.
module frame_memory_unit
    import gpu_mem_pkg::*;
#(
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int ROW_PIXELS = SLICE_W,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 1 << ADDR_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic                           a_wren,
    input  logic [ADDR_W-1:0]              a_addr,
    input  logic [CHANNELS*ROW_PIXELS-1:0] a_data,
    input  logic [ROW_PIXELS-1:0]          a_mask,
    output logic                           a_rvalid,
    output logic [CHANNELS*ROW_PIXELS-1:0] a_q,
    input  logic                           b_en,
    input  logic [ADDR_W-1:0]              b_addr,
    output logic                           b_rvalid,
    output logic [CHANNELS*ROW_PIXELS-1:0] b_q,
    input  logic                           clear_start,
    input  logic [CHANNELS-1:0]            clear_value,
    output logic                           clear_busy,
    output logic                           clear_done
);

    fmu_state_t            state;
    logic [ADDR_W-1:0]     cnt;
    logic [CHANNELS-1:0]   fill;
    logic                  accept;
    logic                  clearing;
    logic                  last_row;
    logic                  we;
    logic                  re;
    logic [ADDR_W-1:0]     w_addr;
    logic [ROW_PIXELS-1:0] w_mask;

    // Reset gates every write so an aborted clear stops on this edge.
    assign accept   = a_valid && a_ready && !reset;
    assign clearing = (state == CLEAR) && !reset;
    assign last_row = cnt == ADDR_W'(DEPTH - 1);
    assign we       = clearing || (accept && a_wren);
    assign re       = accept && !a_wren;
    assign w_addr   = clearing ? cnt : a_addr;
    assign w_mask   = clearing ? '1 : a_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fill       <= '0;
            a_ready    <= 1'b1;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            a_rvalid   <= re;
            b_rvalid   <= b_en;
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        fill       <= clear_value;
                        a_ready    <= 1'b0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (last_row) begin
                        state      <= DONE;
                        clear_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    a_ready    <= 1'b1;
                    clear_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_plane
        logic [ROW_PIXELS-1:0] w_data;

        assign w_data = clearing ? {ROW_PIXELS{fill[c]}}
                                 : a_data[c*ROW_PIXELS +: ROW_PIXELS];

        frame_plane_ram #(
            .ROW_PIXELS (ROW_PIXELS),
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH)
        ) u_ram (
            .clock  (clock),
            .reset  (reset),
            .a_we   (we),
            .a_re   (re),
            .a_addr (w_addr),
            .a_mask (w_mask),
            .a_data (w_data),
            .a_q    (a_q[c*ROW_PIXELS +: ROW_PIXELS]),
            .b_en   (b_en),
            .b_addr (b_addr),
            .b_q    (b_q[c*ROW_PIXELS +: ROW_PIXELS])
        );
    end

endmodule

// File: tb/tb_frame_memory_unit.sv
// Bench for frame_memory_unit: vector table, clear sequences and a
// read-data scoreboard on both ports.
module tb_frame_memory_unit;

    localparam int CH    = 3;
    localparam int RP    = 256;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int DW    = CH * RP;

    localparam logic [1:0] OP_W  = 2'd0;
    localparam logic [1:0] OP_RA = 2'd1;
    localparam logic [1:0] OP_RB = 2'd2;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [RP-1:0] mask;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_valid;
    logic          a_ready;
    logic          a_wren;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic [RP-1:0] a_mask;
    logic          a_rvalid;
    logic [DW-1:0] a_q;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic          b_rvalid;
    logic [DW-1:0] b_q;
    logic          clear_start;
    logic [CH-1:0] clear_value;
    logic          clear_busy;
    logic          clear_done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] snap  [DEPTH];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    vec_t          tbl [13];

    frame_memory_unit #(
        .CHANNELS   (CH),
        .ROW_PIXELS (RP),
        .ADDR_W     (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_wren      (a_wren),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_mask      (a_mask),
        .a_rvalid    (a_rvalid),
        .a_q         (a_q),
        .b_en        (b_en),
        .b_addr      (b_addr),
        .b_rvalid    (b_rvalid),
        .b_q         (b_q),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chki(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] fill_word(logic [CH-1:0] v);
        logic [DW-1:0] w;
        for (int c = 0; c < CH; c++) w[c*RP +: RP] = {RP{v[c]}};
        return w;
    endfunction

    function automatic vec_t vec(logic [1:0] op, int addr, logic [DW-1:0] d,
                                 logic [RP-1:0] m, logic [DW-1:0] e);
        vec_t v;
        v.op   = op;
        v.addr = AW'(addr);
        v.data = d;
        v.mask = m;
        v.exp  = e;
        return v;
    endfunction

    // Scoreboard: every rvalid must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (a_rvalid) begin
                if (qa.size() == 0) chki("a_rvalid_unexpected", 1, 0);
                else chk("a_q", a_q, qa.pop_front());
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chki("b_rvalid_unexpected", 1, 0);
                else chk("b_q", b_q, qb.pop_front());
            end
        end
    end

    task automatic a_op(input logic wr, input int addr, input logic [DW-1:0] d,
                        input logic [RP-1:0] m, input logic [DW-1:0] e);
        int n = 0;
        a_valid = 1'b1;
        a_wren  = wr;
        a_addr  = AW'(addr);
        a_data  = d;
        a_mask  = m;
        while (!a_ready && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        if (!a_ready) chki("a_ready_timeout", 0, 1);
        if (wr) model[addr] = (model[addr] & ~{CH{m}}) | (d & {CH{m}});
        else qa.push_back(e);
        @(posedge clock); #1;
        a_valid = 1'b0;
        chki("a_rvalid_latency", int'(a_rvalid), int'(!wr));
    endtask

    task automatic b_rd(input int addr, input logic [DW-1:0] e);
        b_en   = 1'b1;
        b_addr = AW'(addr);
        qb.push_back(e);
        @(posedge clock); #1;
        b_en = 1'b0;
        chki("b_rvalid_latency", int'(b_rvalid), 1);
    endtask

    // mode 0: no scanout, 1: sweep rows alongside the clear, 2: watch row 9.
    task automatic do_clear(input logic [CH-1:0] v, input int mode,
                            input bit restart, input int abort_at,
                            input bit wr9, input logic [DW-1:0] d9);
        logic [DW-1:0] fw;
        int busy_n = 0;
        int low_n  = 0;
        int done_n = 0;
        int done_at = -1;
        int bv_n = 0;
        int r;
        int lim;
        fw = fill_word(v);
        clear_start = 1'b1;
        clear_value = v;
        if (wr9) begin
            chki("a_ready_before_clear", int'(a_ready), 1);
            a_valid = 1'b1;
            a_wren  = 1'b1;
            a_addr  = AW'(9);
            a_data  = d9;
            a_mask  = '1;
            model[9] = d9;
        end
        snap = model;
        @(posedge clock); #1;
        clear_start = 1'b0;
        clear_value = ~v;
        a_valid = 1'b0;
        lim = (abort_at >= 0) ? abort_at + 6 : DEPTH + 10;
        for (int i = 0; i < lim; i++) begin
            if (clear_busy) busy_n++;
            if (!a_ready) low_n++;
            if (clear_done) begin
                done_n++;
                done_at = i;
            end
            if (mode != 0 && i >= 1 && i <= DEPTH && b_rvalid) bv_n++;
            b_en = 1'b0;
            reset = 1'b0;
            clear_start = 1'b0;
            if (mode != 0 && i < DEPTH) begin
                r = (mode == 1) ? ((i % 2 == 0) ? i : i - 1) : 9;
                b_en   = 1'b1;
                b_addr = AW'(r);
                qb.push_back((r < i) ? fw : snap[r]);
            end
            if (restart && i == 500) begin
                clear_start = 1'b1;
                clear_value = CH'(2);
            end
            if (i == abort_at) reset = 1'b1;
            @(posedge clock); #1;
        end
        b_en = 1'b0;
        clear_start = 1'b0;
        reset = 1'b0;
        if (abort_at < 0) begin
            chki("clear_busy_cycles", busy_n, DEPTH + 1);
            chki("a_ready_low_cycles", low_n, DEPTH + 1);
            chki("clear_done_pulses", done_n, 1);
            chki("clear_done_cycle", done_at, DEPTH);
            if (mode != 0) chki("b_rvalid_continuous", bv_n, DEPTH);
            for (int k = 0; k < DEPTH; k++) model[k] = fw;
        end else begin
            chki("abort_no_done", done_n, 0);
            chki("abort_a_ready", int'(a_ready), 1);
            chki("abort_busy", int'(clear_busy), 0);
            for (int k = 0; k < abort_at; k++) model[k] = fw;
        end
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] pat;
        logic [RP-1:0] msb;
        logic [RP-1:0] mid;

        ones = '1;
        pat  = {{8{32'h0F0F_1234}}, {8{32'hCAFE_F00D}}, {8{32'h1357_9BDF}}};
        msb  = {1'b1, {(RP-1){1'b0}}};
        mid  = RP'(32'hFFFF_0000);

        tbl[0]  = vec(OP_W,  5, ones, '1, '0);
        tbl[1]  = vec(OP_RA, 5, '0, '0, ones);
        tbl[2]  = vec(OP_RB, 5, '0, '0, ones);
        tbl[3]  = vec(OP_W,  7, '0, '1, '0);
        tbl[4]  = vec(OP_W,  7, ones, RP'(8'hFF), '0);
        tbl[5]  = vec(OP_RA, 7, '0, '0, {CH{RP'(8'hFF)}});
        tbl[6]  = vec(OP_RB, 7, '0, '0, {CH{RP'(8'hFF)}});
        tbl[7]  = vec(OP_W,  0, pat, '1, '0);
        tbl[8]  = vec(OP_W,  0, '0, mid, '0);
        tbl[9]  = vec(OP_RA, 0, '0, '0, pat & ~{CH{mid}});
        tbl[10] = vec(OP_W,  1023, ones, msb, '0);
        tbl[11] = vec(OP_RB, 1023, '0, '0, {msb, {RP{1'b1}}, msb});
        tbl[12] = vec(OP_RA, 3, '0, '0, {{RP{1'b0}}, {RP{1'b1}}, {RP{1'b0}}});

        reset = 1'b1;
        a_valid = 1'b0;
        a_wren = 1'b0;
        a_addr = '0;
        a_data = '0;
        a_mask = '0;
        b_en = 1'b0;
        b_addr = '0;
        clear_start = 1'b0;
        clear_value = '0;
        repeat (3) @(posedge clock);
        #1;
        chki("rst_a_ready", int'(a_ready), 1);
        chki("rst_a_rvalid", int'(a_rvalid), 0);
        chki("rst_b_rvalid", int'(b_rvalid), 0);
        chki("rst_clear_busy", int'(clear_busy), 0);
        chki("rst_clear_done", int'(clear_done), 0);
        chk("rst_a_q", a_q, '0);
        chk("rst_b_q", b_q, '0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_clear(CH'(2), 0, 1'b0, -1, 1'b0, '0);

        for (int i = 0; i < 13; i++) begin
            case (tbl[i].op)
                OP_W:  a_op(1'b1, int'(tbl[i].addr), tbl[i].data, tbl[i].mask, '0);
                OP_RA: a_op(1'b0, int'(tbl[i].addr), '0, '0, tbl[i].exp);
                default: b_rd(int'(tbl[i].addr), tbl[i].exp);
            endcase
        end
        a_op(1'b1, 20, pat, '1, '0);
        @(posedge clock); #1;
        chk("a_q_hold", a_q, tbl[12].exp);

        do_clear(CH'(5), 1, 1'b0, -1, 1'b0, '0);
        a_op(1'b0, 0, '0, '0, fill_word(CH'(5)));
        a_op(1'b0, 512, '0, '0, fill_word(CH'(5)));
        a_op(1'b0, 1023, '0, '0, fill_word(CH'(5)));
        b_rd(77, fill_word(CH'(5)));

        do_clear(CH'(6), 2, 1'b1, -1, 1'b1, pat);
        a_op(1'b0, 9, '0, '0, fill_word(CH'(6)));
        b_rd(1023, fill_word(CH'(6)));

        do_clear(CH'(7), 0, 1'b0, 300, 1'b0, '0);
        b_rd(0, fill_word(CH'(7)));
        b_rd(299, model[299]);
        a_op(1'b0, 299, '0, '0, fill_word(CH'(7)));
        a_op(1'b0, 300, '0, '0, fill_word(CH'(6)));
        a_op(1'b0, 301, '0, '0, model[301]);
        a_op(1'b0, 1023, '0, '0, fill_word(CH'(6)));

        repeat (3) @(posedge clock);
        #1;
        chki("qa_drained", qa.size(), 0);
        chki("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
